// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage
//  Purpose  : Pipeline execute stage with ALU, shifter, 1Kx16 data memory
//             and a 16-step iterative shift-add multiplier that stalls upstream.
//  Revision : 1.0  initial release
// ============================================================================
module execute_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic [6:0]  op_cc_in,
   input  logic [15:0] addr,
   input  logic [15:0] data,
   input  logic [3:0]  dest_in,
   output logic        stall,
   output logic [15:0] pc_follow,
   output logic [6:0]  op_cc_out,
   output logic [15:0] value_out,
   output logic [3:0]  dest_out,
   output logic        wr_en_out,
   output logic        z_out
);

   localparam logic [4:0] c_OP_ADD  = 5'd0;
   localparam logic [4:0] c_OP_ADDF = 5'd1;
   localparam logic [4:0] c_OP_AND  = 5'd2;
   localparam logic [4:0] c_OP_BIC  = 5'd3;
   localparam logic [4:0] c_OP_EOR  = 5'd4;
   localparam logic [4:0] c_OP_FTOI = 5'd5;
   localparam logic [4:0] c_OP_ITOF = 5'd6;
   localparam logic [4:0] c_OP_LDR  = 5'd7;
   localparam logic [4:0] c_OP_MOV  = 5'd8;
   localparam logic [4:0] c_OP_MUL  = 5'd9;
   localparam logic [4:0] c_OP_MULF = 5'd10;
   localparam logic [4:0] c_OP_NEG  = 5'd11;
   localparam logic [4:0] c_OP_NOP  = 5'd12;
   localparam logic [4:0] c_OP_ORR  = 5'd13;
   localparam logic [4:0] c_OP_PRE  = 5'd14;
   localparam logic [4:0] c_OP_RECF = 5'd15;
   localparam logic [4:0] c_OP_SHA  = 5'd16;
   localparam logic [4:0] c_OP_SLT  = 5'd17;
   localparam logic [4:0] c_OP_STR  = 5'd18;
   localparam logic [4:0] c_OP_SUB  = 5'd19;
   localparam logic [4:0] c_OP_SUBF = 5'd20;
   localparam logic [4:0] c_OP_SYS  = 5'd21;

   localparam logic [1:0] c_CC_AL = 2'd0;
   localparam logic [1:0] c_CC_S  = 2'd3;

   localparam logic [6:0] c_BUBBLE = {c_OP_NOP, c_CC_AL};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_cnt;
   logic [15:0] r_mcand;
   logic [15:0] r_mplier;
   logic [15:0] r_acc;
   logic [15:0] r_pc_l;
   logic [6:0]  r_op_cc_l;
   logic [3:0]  r_dest_l;

   logic [15:0] r_pc_follow;
   logic [6:0]  r_op_cc_out;
   logic [15:0] r_value_out;
   logic [3:0]  r_dest_out;
   logic        r_wr_en_out;
   logic        r_z;

   logic [15:0] r_mem [0:1023];

   logic [4:0]  w_op;
   logic [1:0]  w_cc;
   logic [15:0] w_alu_val;
   logic        w_alu_we;
   logic [3:0]  w_neg_amt;
   logic [15:0] w_mul_result;
   logic        w_start_mul;
   logic        w_mul_done;

   assign w_op      = op_cc_in[6:2];
   assign w_cc      = op_cc_in[1:0];
   assign w_neg_amt = 4'd0 - data[3:0];

   // Last multiplier bit step is folded into the result write.
   assign w_mul_result = r_acc + (r_mplier[0] ? r_mcand : 16'd0);

   always_comb begin
      w_alu_val = 16'd0;
      w_alu_we  = 1'b0;
      case (w_op)
         c_OP_ADD: begin w_alu_val = addr + data;   w_alu_we = 1'b1; end
         c_OP_SUB: begin w_alu_val = addr - data;   w_alu_we = 1'b1; end
         c_OP_AND: begin w_alu_val = addr & data;   w_alu_we = 1'b1; end
         c_OP_ORR: begin w_alu_val = addr | data;   w_alu_we = 1'b1; end
         c_OP_EOR: begin w_alu_val = addr ^ data;   w_alu_we = 1'b1; end
         c_OP_BIC: begin w_alu_val = addr & ~data;  w_alu_we = 1'b1; end
         c_OP_MOV: begin w_alu_val = data;          w_alu_we = 1'b1; end
         c_OP_NEG: begin w_alu_val = 16'd0 - data;  w_alu_we = 1'b1; end
         c_OP_LDR: begin w_alu_val = r_mem[data[9:0]]; w_alu_we = 1'b1; end
         c_OP_SLT: begin
            w_alu_val = {15'd0, ($signed(addr) < $signed(data))};
            w_alu_we  = 1'b1;
         end
         c_OP_SHA: begin
            w_alu_we = 1'b1;
            if (!data[15])
               w_alu_val = (data > 16'd15) ? 16'd0 : (addr << data[3:0]);
            else if ($signed(data) < -16'sd15)
               w_alu_val = {16{addr[15]}};
            else
               w_alu_val = $unsigned($signed(addr) >>> w_neg_amt);
         end
         default: begin w_alu_val = 16'd0; w_alu_we = 1'b0; end
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      stall        = 1'b0;
      w_start_mul  = 1'b0;
      w_mul_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_op == c_OP_MUL) begin
               stall        = 1'b1;
               w_start_mul  = 1'b1;
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt == 4'd15) begin
               w_mul_done   = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_mcand     <= 16'd0;
         r_mplier    <= 16'd0;
         r_acc       <= 16'd0;
         r_pc_l      <= 16'd0;
         r_op_cc_l   <= c_BUBBLE;
         r_dest_l    <= 4'd0;
         r_z         <= 1'b0;
         r_pc_follow <= 16'd0;
         r_op_cc_out <= c_BUBBLE;
         r_value_out <= 16'd0;
         r_dest_out  <= 4'd0;
         r_wr_en_out <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (w_start_mul) begin
            r_mcand   <= addr;
            r_mplier  <= data;
            r_acc     <= 16'd0;
            r_cnt     <= 4'd0;
            r_pc_l    <= pc;
            r_op_cc_l <= op_cc_in;
            r_dest_l  <= dest_in;
         end else if (w_mul_done) begin
            r_cnt <= 4'd0;
         end else if (r_state == ST_BUSY) begin
            r_acc    <= w_mul_result;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 4'd1;
         end

         if (w_mul_done) begin
            r_pc_follow <= r_pc_l;
            r_op_cc_out <= r_op_cc_l;
            r_dest_out  <= r_dest_l;
            r_value_out <= w_mul_result;
            r_wr_en_out <= 1'b1;
            if (r_op_cc_l[1:0] == c_CC_S)
               r_z <= (w_mul_result == 16'd0);
         end else if (stall) begin
            r_pc_follow <= 16'd0;
            r_op_cc_out <= c_BUBBLE;
            r_dest_out  <= 4'd0;
            r_value_out <= 16'd0;
            r_wr_en_out <= 1'b0;
         end else begin
            r_pc_follow <= pc;
            r_op_cc_out <= op_cc_in;
            r_dest_out  <= dest_in;
            r_value_out <= w_alu_val;
            r_wr_en_out <= w_alu_we;
            if (w_cc == c_CC_S && w_alu_we)
               r_z <= (w_alu_val == 16'd0);
         end
      end
   end

   // Memory has no reset; the write is gated so a store during reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && r_state == ST_IDLE && w_op == c_OP_STR)
         r_mem[data[9:0]] <= addr;
   end

   assign pc_follow = r_pc_follow;
   assign op_cc_out = r_op_cc_out;
   assign value_out = r_value_out;
   assign dest_out  = r_dest_out;
   assign wr_en_out = r_wr_en_out;
   assign z_out     = r_z;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_stage
//  Purpose  : Randomized self-checking bench for execute_stage against an
//             instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_execute_stage;

   localparam logic [4:0] c_ADD = 5'd0,  c_ADDF = 5'd1,  c_AND = 5'd2,  c_BIC = 5'd3;
   localparam logic [4:0] c_EOR = 5'd4,  c_FTOI = 5'd5,  c_ITOF = 5'd6, c_LDR = 5'd7;
   localparam logic [4:0] c_MOV = 5'd8,  c_MUL = 5'd9,   c_MULF = 5'd10, c_NEG = 5'd11;
   localparam logic [4:0] c_NOP = 5'd12, c_ORR = 5'd13,  c_PRE = 5'd14, c_RECF = 5'd15;
   localparam logic [4:0] c_SHA = 5'd16, c_SLT = 5'd17,  c_STR = 5'd18, c_SUB = 5'd19;
   localparam logic [4:0] c_SUBF = 5'd20, c_SYS = 5'd21;
   localparam logic [1:0] c_AL = 2'd0, c_NE = 2'd1, c_EQ = 2'd2, c_S = 2'd3;
   localparam logic [6:0] c_BUBBLE = {5'd12, 2'd0};

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic [6:0]  op_cc_in;
   logic [15:0] addr;
   logic [15:0] data;
   logic [3:0]  dest_in;
   logic        stall;
   logic [15:0] pc_follow;
   logic [6:0]  op_cc_out;
   logic [15:0] value_out;
   logic [3:0]  dest_out;
   logic        wr_en_out;
   logic        z_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mem_model [int];
   int          addr_q [$];
   logic        z_model;

   execute_stage dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .op_cc_in  (op_cc_in),
      .addr      (addr),
      .data      (data),
      .dest_in   (dest_in),
      .stall     (stall),
      .pc_follow (pc_follow),
      .op_cc_out (op_cc_out),
      .value_out (value_out),
      .dest_out  (dest_out),
      .wr_en_out (wr_en_out),
      .z_out     (z_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural result of one instruction, from the instruction-set rules.
   function automatic void model(input logic [4:0] op, input logic [15:0] rd,
                                 input logic [15:0] op2,
                                 output logic [15:0] val, output logic we);
      int s;
      int r;
      s  = int'($signed(op2));
      r  = int'($signed(rd));
      we = 1'b1;
      case (op)
         c_ADD: val = 16'(rd + op2);
         c_SUB: val = 16'(rd - op2);
         c_AND: val = rd & op2;
         c_ORR: val = rd | op2;
         c_EOR: val = rd ^ op2;
         c_BIC: val = rd & ~op2;
         c_MOV: val = op2;
         c_NEG: val = 16'(0 - int'(op2));
         c_MUL: val = 16'(int'(rd) * int'(op2));
         c_SLT: val = (r < s) ? 16'd1 : 16'd0;
         c_LDR: val = mem_model[int'(op2[9:0])];
         c_SHA: begin
            if (s >= 16)       val = 16'd0;
            else if (s >= 0)   val = 16'(int'(rd) << s);
            else if (s <= -16) val = (r < 0) ? 16'hFFFF : 16'h0000;
            else               val = 16'(r >>> (-s));
         end
         default: begin val = 16'd0; we = 1'b0; end
      endcase
   endfunction

   task automatic check_bubble(input string tag);
      check({tag, "_opcc"}, 32'(op_cc_out), 32'(c_BUBBLE));
      check({tag, "_we"},   32'(wr_en_out), 32'd0);
      check({tag, "_val"},  32'(value_out), 32'd0);
      check({tag, "_z"},    32'(z_out),     32'(z_model));
   endtask

   task automatic scramble();
      pc       = 16'($urandom);
      op_cc_in = 7'($urandom);
      addr     = 16'($urandom);
      data     = 16'($urandom);
      dest_in  = 4'($urandom);
   endtask

   // Called just after a posedge; returns just after the posedge that
   // delivers the instruction's result, with its outputs checked.
   task automatic exec(input logic [4:0] op, input logic [1:0] cc, input logic [15:0] rd,
                       input logic [15:0] op2, input logic [3:0] dst);
      logic [15:0] pcv;
      logic [15:0] ev;
      logic        ew;
      pcv      = 16'($urandom);
      pc       = pcv;
      op_cc_in = {op, cc};
      addr     = rd;
      data     = op2;
      dest_in  = dst;
      model(op, rd, op2, ev, ew);
      #1;
      if (op == c_MUL) begin
         check("mul_stall_first", 32'(stall), 32'd1);
         @(posedge clk); #1;
         check_bubble("mul_bub");
         for (int i = 0; i < 15; i++) begin
            scramble();
            #1 check("mul_stall_busy", 32'(stall), 32'd1);
            @(posedge clk); #1;
            check_bubble("mul_bub");
         end
         scramble();
         #1 check("mul_stall_last", 32'(stall), 32'd0);
      end else begin
         check("stall_low", 32'(stall), 32'd0);
         if (op == c_STR) begin
            mem_model[int'(op2[9:0])] = rd;
            addr_q.push_back(int'(op2[9:0]));
         end
      end
      @(posedge clk); #1;
      if (cc == c_S && ew) z_model = (ev == 16'd0);
      check("pc_follow", 32'(pc_follow), 32'(pcv));
      check("op_cc_out", 32'(op_cc_out), 32'({op, cc}));
      check("dest_out",  32'(dest_out),  32'(dst));
      check("value_out", 32'(value_out), 32'(ev));
      check("wr_en_out", 32'(wr_en_out), 32'(ew));
      check("z_out",     32'(z_out),     32'(z_model));
   endtask

   initial begin
      logic [4:0]  ops [22];
      logic [4:0]  op;
      logic [15:0] rd;
      logic [15:0] op2;
      ops = '{c_ADD, c_ADDF, c_AND, c_BIC, c_EOR, c_FTOI, c_ITOF, c_LDR, c_MOV, c_MUL, c_MULF,
              c_NEG, c_NOP, c_ORR, c_PRE, c_RECF, c_SHA, c_SLT, c_STR, c_SUB, c_SUBF, c_SYS};

      reset = 1'b1;
      pc = 16'h1234; op_cc_in = {c_NOP, c_AL}; addr = 16'h0; data = 16'h0; dest_in = 4'h7;
      z_model = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",    32'(pc_follow), 32'd0);
      check("rst_opcc",  32'(op_cc_out), 32'(c_BUBBLE));
      check("rst_val",   32'(value_out), 32'd0);
      check("rst_dest",  32'(dest_out),  32'd0);
      check("rst_we",    32'(wr_en_out), 32'd0);
      check("rst_z",     32'(z_out),     32'd0);
      check("rst_stall", 32'(stall),     32'd0);
      reset = 1'b0;

      exec(c_ADD, c_S, 16'h0005, 16'hFFFB, 4'd1);
      check("add_zero_z", 32'(z_out), 32'd1);
      exec(c_SUB, c_AL, 16'h0003, 16'h0003, 4'd2);
      check("sub_al_z_hold", 32'(z_out), 32'd1);
      exec(c_ORR, c_S, 16'h0000, 16'h0001, 4'd3);
      check("orr_s_z_clear", 32'(z_out), 32'd0);

      exec(c_MUL, c_AL, 16'h0123, 16'h0010, 4'd4);
      check("mul_value", 32'(value_out), 32'h1230);
      check("mul_stall_after", 32'(stall), 32'd0);

      exec(c_STR, c_AL, 16'hBEEF, 16'h0040, 4'd5);
      check("str_no_we", 32'(wr_en_out), 32'd0);
      exec(c_LDR, c_AL, 16'h0000, 16'h0040, 4'd6);
      check("ldr_after_str", 32'(value_out), 32'hBEEF);

      exec(c_SHA, c_AL, 16'h8000, 16'hFFFC, 4'd7);
      check("sha_neg", 32'(value_out), 32'hF800);
      exec(c_SHA, c_AL, 16'h0001, 16'h0014, 4'd8);
      check("sha_big", 32'(value_out), 32'h0000);
      exec(c_SLT, c_AL, 16'hFFFF, 16'h0001, 4'd9);
      check("slt_signed", 32'(value_out), 32'h0001);
      exec(c_SYS, c_S, 16'h0000, 16'h0000, 4'd10);

      // A store coincident with reset must leave memory unchanged.
      exec(c_STR, c_AL, 16'hAAAA, 16'h0050, 4'd0);
      reset = 1'b1; op_cc_in = {c_STR, c_AL}; addr = 16'h1234; data = 16'h0050;
      @(posedge clk); #1;
      reset = 1'b0; z_model = 1'b0;
      exec(c_LDR, c_AL, 16'h0000, 16'h0050, 4'd11);
      check("str_in_reset", 32'(value_out), 32'hAAAA);

      // Reset in the middle of a multiply.
      exec(c_ADD, c_S, 16'h0001, 16'hFFFF, 4'd1);
      pc = 16'h0100; op_cc_in = {c_MUL, c_S}; addr = 16'h0003; data = 16'h0005; dest_in = 4'd2;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1; op_cc_in = {c_NOP, c_AL};
      @(posedge clk); #1;
      reset = 1'b0; z_model = 1'b0;
      check("busy_rst_stall", 32'(stall), 32'd0);
      check("busy_rst_opcc",  32'(op_cc_out), 32'(c_BUBBLE));
      check("busy_rst_z",     32'(z_out), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("busy_rst_no_mul", 32'(wr_en_out), 32'd0);
      end

      for (int n = 0; n < 300; n++) begin
         op  = ops[$urandom_range(0, 21)];
         rd  = 16'($urandom);
         op2 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) op2 = rd;
         if (op == c_SHA) op2 = 16'($urandom_range(0, 40) - 20);
         if (op == c_LDR) begin
            if (addr_q.size() == 0) op = c_STR;
            else op2 = {6'($urandom), 10'(addr_q[$urandom_range(0, addr_q.size() - 1)])};
         end
         exec(op, 2'($urandom), rd, op2, 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port pc  input  16  PC of the instruction presented by the register-read stage.
REQ-004 SHALL have port op_cc_in  input  7  {opcode[4:0], cc[1:0]} of the presented instruction.
REQ-005 SHALL have port addr  input  16  Rd register value (first operand, store data).
REQ-006 SHALL have port data  input  16  resolved op2 value (immediate, prefixed immediate or register).
REQ-007 SHALL have port dest_in  input  4  Rd register number.
REQ-008 SHALL have port stall  output  1  high means upstream holds the current inputs.
REQ-009 SHALL have ports pc_follow (16), op_cc_out (7), value_out (16), dest_out (4), wr_en_out (1), z_out (1), all registered outputs.

Function
REQ-010 SHALL, for non-MUL ops, register results one posedge after presentation; pc_follow, op_cc_out, dest_out copy inputs.
REQ-011 SHALL compute, 16-bit wraparound: ADD Rd+op2; SUB Rd-op2; AND Rd&op2; ORR Rd|op2; EOR Rd^op2; BIC Rd&~op2; MOV op2; NEG 0-op2.
REQ-012 SHALL compute SLT as 1 if signed Rd < signed op2, else 0.
REQ-013 SHALL compute SHA as signed op2 shift of Rd: positive left (zero fill), negative arithmetic right; |op2| >= 16 gives 0 left or sign-fill right.
REQ-014 SHALL contain a 1024x16 data memory indexed by op2[9:0]; LDR value_out = mem[op2]; STR writes mem[op2] = Rd at the posedge; contents not reset.
REQ-015 SHALL read memory combinationally so an LDR immediately after an STR to the same address returns the stored value.
REQ-016 SHALL drive wr_en_out=1 for ADD, AND, BIC, EOR, LDR, MOV, MUL, NEG, ORR, SHA, SLT, SUB; 0 for STR, NOP, SYS, PRE and all float opcodes (ADDF, FTOI, ITOF, MULF, RECF, SUBF), which produce value_out=0.
REQ-017 SHALL update Z (z_out) to (result==0) only when cc==S and wr_en_out would be 1; cc AL/NE/EQ leave Z unchanged.
REQ-018 SHALL implement MUL as an iterative shift-add multiplier, low 16 bits of Rd*op2, with states IDLE and BUSY and a 4-bit step counter.
REQ-019 SHALL, in IDLE with MUL presented: drive stall=1 combinationally, latch operands/pc/op_cc/dest, counter=0, enter BUSY at the posedge.
REQ-020 SHALL, in BUSY, perform one multiplier bit step per cycle and increment counter; stall=1 while counter<15, stall=0 when counter==15.
REQ-021 SHALL, at the posedge with counter==15, write MUL result, latched pc/op_cc/dest, wr_en_out=1 (Z per REQ-017), return to IDLE; total 17 posedges presentation-to-output.
REQ-022 SHALL emit a bubble (op_cc_out={NOP,AL}, wr_en_out=0, value_out=0, Z unchanged) on every posedge where stall was high.
REQ-023 SHALL ignore input changes while BUSY; only latched operands are used.
REQ-024 SHALL pass SYS through with wr_en_out=0 so downstream halts on it.

Reset
REQ-025 SHALL, on posedge with reset=1, set state=IDLE, counter=0, Z=0, pc_follow=0, op_cc_out={NOP,AL}, value_out=0, dest_out=0, wr_en_out=0.
REQ-026 SHALL give reset priority over all ops; reset during BUSY discards the pending MUL and drops stall on the next cycle.
REQ-027 SHALL leave data memory untouched by reset; an STR coincident with reset SHALL NOT write.

Verification
REQ-028 ADD cc=S, Rd=0x0005, op2=0xFFFB -> next posedge value_out=0x0000, wr_en_out=1, z_out=1.
REQ-029 MUL Rd=0x0123, op2=0x0010 -> stall high 16 cycles, bubbles output, 17th posedge value_out=0x1230, wr_en_out=1, stall low.
REQ-030 STR Rd=0xBEEF op2=0x0040 then LDR op2=0x0040 -> STR wr_en_out=0; LDR value_out=0xBEEF.
REQ-031 SHA Rd=0x8000 op2=0xFFFC -> 0xF800; SHA Rd=0x0001 op2=0x0014 -> 0x0000; SLT Rd=0xFFFF op2=0x0001 -> 0x0001.
REQ-032 Reset asserted at BUSY counter=7 -> next cycle stall=0, op_cc_out={NOP,AL}, z_out=0, no MUL result ever emitted.
REQ-033 SUB cc=AL giving 0 after Z=1 set, then ORR cc=S giving 0x0001 -> Z stays 1 then becomes 0.
